led_frame_buffer: RTL
=====================

Name: led_frame_buffer

Overview:
Double-buffered 4x8 frame store that sits directly upstream of LedMatrix and drives its four 8-bit row inputs. A producer (pattern generator, button handler, scroller) writes row words into a back buffer through a valid/ready port, then requests a commit. The block copies the back buffer to the front buffer only on an internal frame tick, so the display never shows a half-written frame. It replaces ad-hoc per-row registers in the top level.

Parameters:
TICK_MSB, 20, MSB of the free-running frame-tick counter; one tick every 2^(TICK_MSB+1) clocks
ROW_BITS, 8, width of each row word; fixed at 8 for the LedMatrix

Ports:
i_clock  in  1  system clock
i_reset_n  in  1  asynchronous active-low reset
i_wr_valid  in  1  write request
o_wr_ready  out  1  back buffer accepts writes
i_wr_addr  in  2  row word index 0..3
i_wr_data  in  ROW_BITS  row word data
i_commit  in  1  request back-to-front copy; sampled as a level each cycle
o_commit_pending  out  1  commit requested, not yet applied
i_blink  in  4  per-row-word blink enable; used only with FB_BLINK_EN
o_row0..o_row3  out  ROW_BITS each  front buffer words, feeding LedMatrix i_row0..i_row3
o_frame_tick  out  1  one-cycle pulse at each swap opportunity
o_swapped  out  1  one-cycle pulse, the cycle after a copy takes effect

Behaviour:
- Clock domain: one clock, i_clock. Reset: asynchronous, active-low, on i_reset_n. Both are fixed.
- On reset:
  - front and back words = 0, so o_row0..3 = 0
  - tick counter = 0
  - state = IDLE
  - o_commit_pending = 0, o_swapped = 0, blink phase = 0
- Tick counter:
  - TICK_MSB+1 bits, free-running, wraps.
  - o_frame_tick = (counter == all ones), decoded combinationally.
  - First tick occurs 2^(TICK_MSB+1)-1 cycles after reset release.
- State IDLE:
  - o_wr_ready = 1.
  - A write is accepted when i_wr_valid && o_wr_ready; back[i_wr_addr] <= i_wr_data at that edge.
  - If i_commit = 1, move to PENDING at the next edge.
  - A write and a commit in the same cycle: the write is included in the commit.
- State PENDING:
  - o_wr_ready = 0; the back buffer is frozen and i_wr_valid is ignored.
  - i_commit is ignored.
  - On an edge where o_frame_tick = 1: front[k] <= back[k] for all k, state <= IDLE, o_swapped <= 1 for one cycle.
  - The back buffer keeps its contents after the copy, so the producer can make incremental edits.
- o_commit_pending = (state == PENDING).
- Commit timing:
  - A commit asserted in IDLE during a tick cycle does not use that tick; it waits for the next one.
  - Commit-to-display latency is 1 to 2^(TICK_MSB+1) cycles after PENDING is entered.
- o_row outputs change only on a copy edge (or reset). They are registered with no combinational path from write inputs.
- Data is stored raw; any active-low inversion is the consumer's concern.
- Reset asserted mid-PENDING: the commit is lost and all storage clears to 0 immediately.

Optional Feature:
FB_BLINK_EN
- Enabled:
  - A blink phase bit toggles on every o_frame_tick.
  - While phase = 1, each o_rowk with i_blink[k] = 1 is driven 0. Otherwise o_rowk = front[k].
  - The phase register resets to 0.
- Disabled:
  - The i_blink port remains but is ignored.
  - o_rowk = front[k]; no phase register exists.

Decomposition:
- Shared package/include: NUM_ROWWORDS = 4, ROW_BITS = 8, state encodings IDLE = 0 and PENDING = 1.
- One natural sub-module: frame_tick_gen, holding the counter and the o_frame_tick decode. It is reusable by the pattern generators.
- The buffer and control logic stay in led_frame_buffer.

Test Plan:
(All scenarios use TICK_MSB = 3, so a tick occurs every 16 cycles.)
1. Reset, then idle 40 cycles -> o_row0..3 = 0; o_frame_tick pulses at cycles 15 and 31; o_wr_ready = 1; o_swapped never set.
2. Write addr 0..3 = 8'hAA, 8'h55, 8'hAA, 8'h55, commit at cycle 5 -> rows stay 0 until the cycle-15 tick edge; then rows = AA/55/AA/55; o_swapped pulses once; pending clears.
3. Commit at cycle 15 (tick cycle) -> no copy at cycle 15; copy at cycle 31.
4. While PENDING, drive i_wr_valid with addr 1 = 8'hFF -> o_wr_ready = 0; write dropped; after the copy, row1 holds the pre-commit value.
5. Write + commit in the same IDLE cycle with addr 2 = 8'h0F -> row2 = 0F after the next tick.
6. Assert i_reset_n low mid-PENDING -> rows, pending and back buffer all 0 immediately; with FB_BLINK_EN and i_blink = 4'b0001, row0 alternates data/0 every 16 cycles.

Source files
------------

// File: rtl/led_frame_buffer_pkg.sv
// Shared constants and state encoding for the LED frame buffer and its helpers.
package led_frame_buffer_pkg;

  localparam int NUM_ROWWORDS = 4;
  localparam int ROW_BITS     = 8;

  typedef enum logic {
    IDLE    = 1'b0,
    PENDING = 1'b1
  } fb_state_e;

endpackage

// File: rtl/frame_tick_gen.sv
// Free-running frame-tick counter; pulses o_frame_tick for one cycle every
// 2^(TICK_MSB+1) clocks, on the cycle the counter holds all ones.
module frame_tick_gen #(
  parameter int TICK_MSB = 20
) (
  input  logic i_clock,
  input  logic i_reset_n,
  output logic o_frame_tick
);

  logic [TICK_MSB:0] count;

  // NOTE: sequential state is updated with non-blocking assignments so every
  // flop samples pre-edge values regardless of statement order.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) count <= '0;
    else            count <= count + 1'b1;
  end

  assign o_frame_tick = &count;

endmodule

// File: rtl/led_frame_buffer.sv
// Double-buffered 4-word frame store feeding LedMatrix; back buffer is copied to
// the front only on a frame tick. Optional blink gating under `FB_BLINK_EN.
module led_frame_buffer #(
  parameter int TICK_MSB = 20,
  parameter int ROW_BITS = led_frame_buffer_pkg::ROW_BITS
) (
  input  logic                i_clock,
  input  logic                i_reset_n,
  input  logic                i_wr_valid,
  output logic                o_wr_ready,
  input  logic [1:0]          i_wr_addr,
  input  logic [ROW_BITS-1:0] i_wr_data,
  input  logic                i_commit,
  output logic                o_commit_pending,
  input  logic [3:0]          i_blink,
  output logic [ROW_BITS-1:0] o_row0,
  output logic [ROW_BITS-1:0] o_row1,
  output logic [ROW_BITS-1:0] o_row2,
  output logic [ROW_BITS-1:0] o_row3,
  output logic                o_frame_tick,
  output logic                o_swapped
);

  import led_frame_buffer_pkg::NUM_ROWWORDS;
  import led_frame_buffer_pkg::fb_state_e;
  import led_frame_buffer_pkg::IDLE;
  import led_frame_buffer_pkg::PENDING;

  fb_state_e           state;
  logic [ROW_BITS-1:0] back_q  [NUM_ROWWORDS];
  logic [ROW_BITS-1:0] front_q [NUM_ROWWORDS];
  logic [ROW_BITS-1:0] row_out [NUM_ROWWORDS];
  logic                frame_tick;
  logic                wr_fire;

  frame_tick_gen #(
    .TICK_MSB(TICK_MSB)
  ) u_tick (
    .i_clock      (i_clock),
    .i_reset_n    (i_reset_n),
    .o_frame_tick (frame_tick)
  );

  assign o_frame_tick     = frame_tick;
  assign o_wr_ready       = (state == IDLE);
  assign o_commit_pending = (state == PENDING);
  assign wr_fire          = i_wr_valid && o_wr_ready;

  // A commit raised during a tick cycle only moves to PENDING at that edge,
  // so it naturally waits for the following tick.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state     <= IDLE;
      o_swapped <= 1'b0;
      // NOTE: these small word arrays are reset on purpose: a reset must blank
      // the display and drop any half-built frame.
      for (int k = 0; k < NUM_ROWWORDS; k++) begin
        back_q[k]  <= '0;
        front_q[k] <= '0;
      end
    end else begin
      o_swapped <= 1'b0;
      case (state)
        IDLE: begin
          if (wr_fire) back_q[i_wr_addr] <= i_wr_data;
          if (i_commit) state <= PENDING;
        end
        PENDING: begin
          if (frame_tick) begin
            front_q   <= back_q;
            state     <= IDLE;
            o_swapped <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef FB_BLINK_EN
  logic blink_phase;

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n)      blink_phase <= 1'b0;
    else if (frame_tick) blink_phase <= ~blink_phase;
  end

  // NOTE: every output of a combinational block gets a value on every path,
  // otherwise synthesis infers a latch.
  always_comb begin
    for (int k = 0; k < NUM_ROWWORDS; k++) begin
      row_out[k] = (blink_phase && i_blink[k]) ? '0 : front_q[k];
    end
  end
`else
  logic blink_unused;
  assign blink_unused = ^i_blink;
  assign row_out      = front_q;
`endif

  assign o_row0 = row_out[0];
  assign o_row1 = row_out[1];
  assign o_row2 = row_out[2];
  assign o_row3 = row_out[3];

endmodule
